io_uart: RTL and testbench
==========================

# io_uart

Byte-stream I/O controller sitting directly downstream of the CPU core's I/O port. Consumes bytes the core emits on its `io_out` valid/ready channel and serialises them onto a UART TX line. Deserialises the UART RX line and offers received bytes on the `io_in` channel. Reports line errors on `io_err`, which the core ORs into its error register while waiting on I/O.

## Interface
- `CLK_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `FIFO_DEPTH`, 16: entries in each of the TX and RX FIFOs; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `io_out_data`  in  8  byte from the core to transmit.
- `io_out_vld`  in  1  core offers `io_out_data`.
- `io_out_rdy`  out  1  TX FIFO can accept a byte.
- `io_in_data`  out  8  head of RX FIFO.
- `io_in_vld`  out  1  RX FIFO non-empty.
- `io_in_rdy`  in  1  core accepts `io_in_data`.
- `io_err`  out  5  error/status bits (see Operation).
- `uart_rx`  in  1  serial input, asynchronous to `clk`, idle high.
- `uart_tx`  out  1  serial output, idle high.

## Operation
- Frame format: 8N1. Start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly `CLK_PER_BIT` cycles.
- Handshakes: a transfer occurs on a rising edge where vld && rdy.
  - `io_out_rdy` = TX FIFO not full.
  - `io_in_vld` = RX FIFO not empty.
  - `io_in_data` is the FIFO head (show-ahead) and is stable while `io_in_vld` is high and no pop occurs.
- TX FSM states: IDLE, START, DATA (3-bit index), STOP. A bit counter counts `CLK_PER_BIT`-1 down to 0 per bit.
  - In IDLE with the FIFO non-empty: pop the FIFO, load the shift register, go to START.
  - STOP end with the FIFO non-empty: pop and go directly to START, giving back-to-back frames with no idle gap.
  - STOP end with the FIFO empty: go to IDLE.
  - `uart_tx` is registered.
- RX path: `uart_rx` passes through a 2-flop synchroniser. FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised falling edge (previous 1, current 0).
  - START samples at `CLK_PER_BIT/2` (integer division). If the sample is 1, it is a false start: return to IDLE with no error. If 0, go to DATA.
  - Each data and stop bit is sampled `CLK_PER_BIT` cycles after the previous sample.
  - After the stop sample, return to IDLE immediately; the line must then show a new falling edge.
- RX FIFO push happens on the cycle after the stop sample, only when stop = 1.
  - Push succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun is set.
- `io_err` bits:
  - [0] framing error: stop sample = 0. Sticky; the byte is discarded.
  - [1] RX overrun. Sticky.
  - [2] break: stop sample = 0 and data = 0x00. Sticky; also sets [0].
  - [3] RX FIFO full. Live level, not sticky.
  - [4] tied 0.
- Sticky bits clear only on reset.
- FIFOs: pointers are log2(`FIFO_DEPTH`)+1 bits; full/empty come from comparing the pointer MSB. Pointers wrap modulo 2·`FIFO_DEPTH`. Simultaneous push and pop leaves the count unchanged, including when full or empty.

## Timing
- Reset values:
  - `uart_tx`=1, `io_out_rdy`=1, `io_in_vld`=0, `io_in_data`=0, `io_err`=0.
  - Both FIFOs empty, both FSMs IDLE, synchroniser flops = 1.
- Reset assertion mid-frame aborts immediately: `uart_tx` goes high asynchronously, and a partial RX byte is lost with no error.
- TX latency: handshake at edge k writes the FIFO. With TX idle, the pop happens at edge k+1 and `uart_tx` falls after edge k+1. The frame then occupies 10·`CLK_PER_BIT` cycles.
- `io_out_rdy` falls the cycle after the FIFO_DEPTH-th unpopped write. It rises the cycle after a pop from full.
- RX latency: `io_in_vld` rises 2 cycles after the stop-bit sample edge (1 cycle to push, 1 cycle for the registered flag). The stop-bit sample itself falls ≈ 3 + 9.5·`CLK_PER_BIT` cycles after the line's falling edge (includes 2 synchroniser cycles).
- Sticky error bits assert in the same cycle the push would have occurred.
- Core pop at edge p: the next head or `io_in_vld`=0 is visible after edge p.

## Test plan
(All scenarios use `CLK_PER_BIT`=8, `FIFO_DEPTH`=4.)
- Single TX:
  - Stimulus: write 0xA5.
  - Required: `uart_tx` low 1 cycle after the handshake for 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high 8 cycles. 80-cycle frame total.
- TX back-pressure:
  - Stimulus: hold `io_out_vld` with 6 bytes 0x01..0x06.
  - Required: `io_out_rdy` drops after 5 accepts (1 popped immediately plus 4 queued). All 6 bytes are emitted in order with no idle gaps between frames.
- RX loopback:
  - Stimulus: tie `uart_tx` to `uart_rx`; send 0x3C, 0xFF, 0x00 with `io_in_rdy`=1.
  - Required: the same bytes appear in order, each with `io_in_vld` high for 1 cycle; `io_err`=0.
- RX overrun:
  - Stimulus: `io_in_rdy`=0; inject 5 frames 0x10..0x14.
  - Required: the FIFO holds 0x10..0x13; `io_err[3]`=1; `io_err[1]` is set when the 5th stop bit completes. Raising `io_in_rdy` yields exactly 4 bytes.
- Framing and break:
  - Stimulus 1: inject 0x55 with stop bit 0.
    - Required: `io_err[0]`=1, nothing pushed.
  - Stimulus 2: inject 0x00 with stop bit 0.
    - Required: `io_err[2]`=1.
- False start and reset:
  - Stimulus 1: a low pulse of 3 cycles on `uart_rx`.
    - Required: no push, no error.
  - Stimulus 2: assert `rstn`=0 mid-TX-frame.
    - Required: `uart_tx`=1 and `io_out_rdy`=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_uart.sv
// Byte-stream UART bridge: core io_out bytes go through a TX FIFO onto uart_tx (8N1),
// uart_rx frames are deserialised into an RX FIFO offered on io_in; line errors on io_err.
module io_uart #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] io_out_data,
  input  logic       io_out_vld,
  output logic       io_out_rdy,
  output logic [7:0] io_in_data,
  output logic       io_in_vld,
  input  logic       io_in_rdy,
  output logic [4:0] io_err,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]    txf_mem [FIFO_DEPTH];
  logic [PW-1:0] txf_wptr_q, txf_wptr_d, txf_rptr_q, txf_rptr_d;
  logic          txf_full, txf_empty, txf_push, txf_pop;

  assign txf_full   = (txf_wptr_q[AW] != txf_rptr_q[AW]) &&
                      (txf_wptr_q[AW-1:0] == txf_rptr_q[AW-1:0]);
  assign txf_empty  = (txf_wptr_q == txf_rptr_q);
  assign io_out_rdy = !txf_full;
  assign txf_push   = io_out_vld && !txf_full;
  assign txf_wptr_d = txf_wptr_q + PW'(txf_push);
  assign txf_rptr_d = txf_rptr_q + PW'(txf_pop);

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wptr_q[AW-1:0]] <= io_out_data;
  end

  // ---------------- TX FSM ----------------
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          uart_tx_q, uart_tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    uart_tx_d  = uart_tx_q;
    txf_pop    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!txf_empty) begin
          txf_pop    = 1'b1;
          tx_sh_d    = txf_mem[txf_rptr_q[AW-1:0]];
          tx_cnt_d   = BIT_LAST;
          uart_tx_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          uart_tx_d  = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
          tx_idx_d   = '0;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_idx_q == 3'd7) begin
            uart_tx_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            uart_tx_d = tx_sh_q[0];
            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
            tx_idx_d  = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next start bit so queued bytes leave without a gap.
          if (!txf_empty) begin
            txf_pop    = 1'b1;
            tx_sh_d    = txf_mem[txf_rptr_q[AW-1:0]];
            tx_cnt_d   = BIT_LAST;
            uart_tx_d  = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      uart_tx_q  <= 1'b1;
      txf_wptr_q <= '0;
      txf_rptr_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      uart_tx_q  <= uart_tx_d;
      txf_wptr_q <= txf_wptr_d;
      txf_rptr_q <= txf_rptr_d;
    end
  end

  assign uart_tx = uart_tx_q;

  // ---------------- RX FSM ----------------
  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_done_q, rx_done_d, rx_stop_q, rx_stop_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_done_d  = 1'b0;
    rx_stop_d  = rx_stop_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_idx_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          rx_cnt_d = BIT_LAST;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_done_d  = 1'b1;
          rx_stop_d  = sync2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO and error flags ----------------
  logic [7:0]    rxf_mem [FIFO_DEPTH];
  logic [PW-1:0] rxf_wptr_q, rxf_wptr_d, rxf_rptr_q, rxf_rptr_d;
  logic          rxf_full, rxf_push, rxf_pop, rx_good;
  logic          rx_vld_q, rx_vld_d;
  logic [7:0]    rx_data_q;
  logic [2:0]    err_q, err_d;

  assign rxf_full   = (rxf_wptr_q[AW] != rxf_rptr_q[AW]) &&
                      (rxf_wptr_q[AW-1:0] == rxf_rptr_q[AW-1:0]);
  assign rxf_pop    = rx_vld_q && io_in_rdy;
  assign rx_good    = rx_done_q && rx_stop_q;
  assign rxf_push   = rx_good && (!rxf_full || rxf_pop);
  assign rxf_wptr_d = rxf_wptr_q + PW'(rxf_push);
  assign rxf_rptr_d = rxf_rptr_q + PW'(rxf_pop);
  // The valid flag sees a push one cycle late but a pop immediately.
  assign rx_vld_d   = (rxf_wptr_q != rxf_rptr_d);

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (rx_done_q && !rx_stop_q);
    err_d[1] = err_q[1] | (rx_good && rxf_full && !rxf_pop);
    err_d[2] = err_q[2] | (rx_done_q && !rx_stop_q && (rx_sh_q == 8'h00));
  end

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem[rxf_wptr_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_done_q  <= 1'b0;
      rx_stop_q  <= 1'b0;
      rxf_wptr_q <= '0;
      rxf_rptr_q <= '0;
      rx_vld_q   <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= '0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_done_q  <= rx_done_d;
      rx_stop_q  <= rx_stop_d;
      rxf_wptr_q <= rxf_wptr_d;
      rxf_rptr_q <= rxf_rptr_d;
      rx_vld_q   <= rx_vld_d;
      rx_data_q  <= rxf_mem[rxf_rptr_d[AW-1:0]];
      err_q      <= err_d;
    end
  end

  assign io_in_vld  = rx_vld_q;
  assign io_in_data = rx_data_q;
  assign io_err     = {1'b0, rxf_full, err_q};

endmodule

// File: tb/tb_io_uart.sv
// Scoreboard bench for io_uart: TX frames and RX bytes are checked by monitors against
// expectation queues filled by the stimulus; error flags come from a frame-level model.
module tb_io_uart;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] io_out_data = '0;
  logic       io_out_vld = 1'b0;
  logic       io_out_rdy;
  logic [7:0] io_in_data;
  logic       io_in_vld;
  logic       io_in_rdy = 1'b0;
  logic [4:0] io_err;
  logic       uart_rx;
  logic       uart_tx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;

  always #5 clk = ~clk;
  assign uart_rx = loop_en ? uart_tx : rx_drv;

  io_uart #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .io_out_data(io_out_data), .io_out_vld(io_out_vld), .io_out_rdy(io_out_rdy),
    .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(io_in_rdy),
    .io_err(io_err), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         tx_start_q[$];
  bit         tx_abort = 1'b0;
  int         rx_pops = 0;
  logic       exp_frm = 1'b0, exp_ovr = 1'b0, exp_brk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_err();
    return {1'b0, (rx_exp_q.size() == DEPTH), exp_brk, exp_ovr, exp_frm};
  endfunction

  // TX monitor: captures 80 samples of every frame and compares with the ideal 8N1 waveform.
  logic       wave [80];
  int         mon_st, mon_bad;
  logic [7:0] mon_got, mon_e;
  logic       mon_bit;
  always begin
    @(negedge clk);
    if (rstn === 1'b1 && uart_tx === 1'b0) begin
      mon_st  = cyc;
      wave[0] = 1'b0;
      for (int j = 1; j < 80; j++) begin
        @(negedge clk);
        wave[j] = uart_tx;
      end
      for (int i = 0; i < 8; i++) mon_got[i] = wave[8 * i + 12];
      if (tx_abort) begin
        tx_abort = 1'b0;
        $display("tx frame at cycle %0d aborted by reset, discarded", mon_st);
      end else if (tx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected_frame: got 0x%02h, expected no frame", mon_got);
      end else begin
        mon_e   = tx_exp_q.pop_front();
        mon_bad = 0;
        for (int j = 0; j < 80; j++) begin
          if (j < 8)       mon_bit = 1'b0;
          else if (j < 72) mon_bit = mon_e[(j - 8) / 8];
          else             mon_bit = 1'b1;
          if (wave[j] !== mon_bit) mon_bad++;
        end
        $display("tx frame at cycle %0d: got 0x%02h expected 0x%02h", mon_st, mon_got, mon_e);
        check($sformatf("tx_frame_%02h_bad_samples", mon_e), mon_bad, 0);
        tx_start_q.push_back(mon_st);
      end
    end
  end

  // RX monitor: every accepted io_in byte must be the next expected one.
  always @(negedge clk) begin
    if (rstn === 1'b1 && io_in_vld === 1'b1 && io_in_rdy === 1'b1) begin
      rx_pops++;
      if (rx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected_byte: got 0x%02h, expected no byte", io_in_data);
      end else begin
        mon_e = rx_exp_q.pop_front();
        $display("rx pop at cycle %0d: got 0x%02h expected 0x%02h", cyc, io_in_data, mon_e);
        check("rx_byte", io_in_data, mon_e);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    tx_exp_q.delete();
    rx_exp_q.delete();
    tx_start_q.delete();
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
    exp_brk = 1'b0;
    rx_pops = 0;
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 io_in_rdy = v;
  endtask

  task automatic tx_write(input logic [7:0] b, input bit expect_it, output int hs, output bit waited);
    int g = 0;
    @(negedge clk);
    io_out_data = b;
    io_out_vld  = 1'b1;
    waited      = 1'b0;
    while (!io_out_rdy && g < 2000) begin
      waited = 1'b1;
      @(negedge clk);
      g++;
    end
    if (!io_out_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_write_timeout: io_out_rdy got 0, required 1 within 2000 cycles");
      io_out_vld = 1'b0;
      hs = -1;
      return;
    end
    if (expect_it) begin
      tx_exp_q.push_back(b);
      if (loop_en) rx_exp_q.push_back(b);
    end
    @(posedge clk);
    #1 hs = cyc;
    io_out_vld = 1'b0;
    $display("tx write 0x%02h accepted at cycle %0d", b, hs);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) begin
      if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
      else                         exp_ovr = 1'b1;
    end else begin
      exp_frm = 1'b1;
      if (b == 8'h00) exp_brk = 1'b1;
    end
    $display("rx inject 0x%02h stop=%0b at cycle %0d", b, stop, cyc);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((tx_exp_q.size() != 0 || (loop_en && rx_exp_q.size() != 0)) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: pending tx %0d rx %0d, required 0", tx_exp_q.size(), rx_exp_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, first_wait;
    bit w;
    logic [7:0] lb [9];
    logic [7:0] rb;
    logic       rs;

    // Reset values, observed while reset is held
    repeat (3) @(negedge clk);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_io_out_rdy", io_out_rdy, 1'b1);
    check("reset_io_in_vld", io_in_vld, 1'b0);
    check("reset_io_in_data", io_in_data, 8'h00);
    check("reset_io_err", io_err, 5'h00);
    rstn = 1'b1;

    // Single TX byte and its start latency
    tx_write(8'hA5, 1'b1, hs, w);
    wait_drain();
    if (tx_start_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_start_latency: got no frame, required start 1 cycle after handshake");
    end else begin
      check("tx_start_latency", tx_start_q[0] - hs, 1);
    end

    // Back-pressure: six bytes offered back to back
    do_reset();
    first_wait = -1;
    for (int i = 0; i < 6; i++) begin
      tx_write(8'(i + 1), 1'b1, hs, w);
      if (w && first_wait < 0) first_wait = i;
    end
    check("tx_accepts_before_full", first_wait, 5);
    wait_drain();
    check("tx_frames_emitted", tx_start_q.size(), 6);
    for (int i = 0; i + 1 < tx_start_q.size(); i++)
      check($sformatf("tx_gap_%0d", i), tx_start_q[i + 1] - tx_start_q[i], 80);

    // Loopback with fixed and random bytes
    do_reset();
    loop_en = 1'b1;
    set_rdy(1'b1);
    lb[0] = 8'h3C;
    lb[1] = 8'hFF;
    lb[2] = 8'h00;
    for (int i = 3; i < 9; i++) lb[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) tx_write(lb[i], 1'b1, hs, w);
    wait_drain();
    check("loop_rx_count", rx_pops, 9);
    check("loop_err", io_err, exp_err());
    loop_en = 1'b0;

    // RX overrun with the core not accepting
    do_reset();
    set_rdy(1'b0);
    for (int i = 0; i < 5; i++) begin
      rx_send(8'(8'h10 + i), 1'b1);
      if (i >= 3) check($sformatf("ovr_err_after_%0d", i + 1), io_err, exp_err());
    end
    check("ovr_head_vld", io_in_vld, 1'b1);
    check("ovr_head_data", io_in_data, rx_exp_q[0]);
    set_rdy(1'b1);
    repeat (20) @(negedge clk);
    check("ovr_pops", rx_pops, 4);
    check("ovr_vld_after_drain", io_in_vld, 1'b0);
    check("ovr_err_after_drain", io_err, exp_err());

    // Random RX frames, occasional bad stop bits
    do_reset();
    set_rdy(1'b1);
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(7) == 0) rb = 8'h00;
      rs = ($urandom_range(3) != 0);
      rx_send(rb, rs);
      check($sformatf("rand_rx_err_%0d", i), io_err, exp_err());
    end
    check("rand_rx_all_popped", rx_exp_q.size(), 0);

    // Framing error, then break
    do_reset();
    set_rdy(1'b1);
    rx_send(8'h55, 1'b0);
    check("framing_err", io_err, exp_err());
    check("framing_no_push", rx_pops, 0);
    rx_send(8'h00, 1'b0);
    check("break_err", io_err, exp_err());
    check("break_no_push", rx_pops, 0);

    // False start: 3-cycle glitch
    do_reset();
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("false_start_err", io_err, 5'h00);
    check("false_start_no_push", rx_pops, 0);
    check("false_start_vld", io_in_vld, 1'b0);

    // Reset mid-frame with a full TX FIFO
    do_reset();
    tx_abort = 1'b1;
    for (int i = 0; i < 5; i++) tx_write(8'h00, 1'b0, hs, w);
    repeat (25) @(negedge clk);
    check("pre_reset_uart_tx", uart_tx, 1'b0);
    check("pre_reset_io_out_rdy", io_out_rdy, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_uart_tx", uart_tx, 1'b1);
    check("async_reset_io_out_rdy", io_out_rdy, 1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    check("post_reset_uart_tx", uart_tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
